// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared definitions for the fetch-stage PC sequencer:
//                FSM state encoding and redirect-kind codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // redirect_kind encodings; 2'b11 falls through to the jump behaviour
  localparam logic [1:0] REDIR_JUMP = 2'b00;
  localparam logic [1:0] REDIR_CALL = 2'b01;
  localparam logic [1:0] REDIR_RET  = 2'b10;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_addr_stack
//  Description : Circular return-address stack. A push onto a full stack
//                overwrites the oldest entry and sets a sticky overflow flag.
//  Ports       : clk, reset        - clock / async active-high reset
//                push_i, pop_i     - mutually exclusive stack operations
//                push_data_i       - link address to push
//                top_o             - most recently pushed entry
//                empty_o, full_o   - derived from the registered count
//                overflow_o        - sticky, cleared only by reset
//  Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  // ptr_q addresses the next slot to write; the top entry sits one below it.
  // Because the stack is circular, when full the next slot is also the
  // oldest entry, so a push there is exactly "overwrite the oldest".
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [PTR_W-1:0] top_idx;

  assign top_idx    = ptr_q - PTR_W'(1);
  assign top_o      = mem_q[top_idx];
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == c_DEPTH);
  assign overflow_o = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (full_o) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_q   <= top_idx;
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule : return_addr_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-stage program-counter sequencer. Presents the PC over
//                a valid/ready handshake, steps by STEP per accepted fetch,
//                and applies traps and jump/call/return redirects with a
//                circular return-address stack and halt/resume control.
//  Ports       : clk, reset          - clock / async active-high reset
//                pc_out, pc_valid    - fetch request
//                fetch_ready         - fetch accepts pc_out this cycle
//                redirect_valid/kind/target - control-flow redirect
//                trap                - highest priority redirect to TRAP_VECTOR
//                halt_req, resume    - halt control
//                ras_empty/full      - stack occupancy
//                ras_overflow/underflow - sticky stack error flags
//                misalign_err        - one-cycle pulse on a misaligned target
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WIDTH        = 64,
  parameter int unsigned     STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(64'h100),
  parameter int unsigned     RAS_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_kind,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  input  logic             halt_req,
  input  logic             resume,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign_err
);

  localparam int unsigned      ALIGN_BITS = $clog2(STEP);
  localparam logic [WIDTH-1:0] c_STEP     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] c_ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             underflow_q, underflow_d;
  logic             misalign_q, misalign_d;

  logic             accept;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] target_aligned;
  logic             target_misaligned;

  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty_w, ras_full_w, ras_overflow_w;

  assign pc_valid          = (state_q == ST_RUN);
  assign accept            = pc_valid & fetch_ready;
  assign pc_plus_step      = pc_q + c_STEP;  // wraps modulo 2^WIDTH
  assign target_aligned    = redirect_target & c_ALIGN_MASK;
  assign target_misaligned = |(redirect_target & ~c_ALIGN_MASK);

  return_addr_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus_step),
    .top_o       (ras_top),
    .empty_o     (ras_empty_w),
    .full_o      (ras_full_w),
    .overflow_o  (ras_overflow_w)
  );

  // Next-state / next-PC: trap > redirect > accept > hold.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    underflow_d = underflow_q;
    misalign_d  = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;

    if (trap) begin
      // Any concurrent redirect is dropped entirely, including its RAS effect.
      state_d = ST_RUN;
      pc_d    = TRAP_VECTOR;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (halt_req) state_d = ST_HALT;
        ST_HALT: if (resume)   state_d = ST_RUN;
        default: state_d = ST_BOOT;
      endcase

      if (redirect_valid) begin
        case (redirect_kind)
          REDIR_CALL: begin
            ras_push   = 1'b1;
            pc_d       = target_aligned;
            misalign_d = target_misaligned;
          end
          REDIR_RET: begin
            if (!ras_empty_w) begin
              // Stack-sourced addresses were pushed aligned; no check.
              ras_pop = 1'b1;
              pc_d    = ras_top;
            end else begin
              pc_d        = target_aligned;
              misalign_d  = target_misaligned;
              underflow_d = 1'b1;
            end
          end
          default: begin
            pc_d       = target_aligned;
            misalign_d = target_misaligned;
          end
        endcase
      end else if (accept) begin
        pc_d = pc_plus_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc_out        = pc_q;
  assign ras_empty     = ras_empty_w;
  assign ras_full      = ras_full_w;
  assign ras_overflow  = ras_overflow_w;
  assign ras_underflow = underflow_q;
  assign misalign_err  = misalign_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [1:0] c_JUMP = 2'b00;
  localparam logic [1:0] c_CALL = 2'b01;
  localparam logic [1:0] c_RET  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [63:0] redirect_target;
  logic        trap;
  logic        halt_req;
  logic        resume;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .trap            (trap),
    .halt_req        (halt_req),
    .resume          (resume),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow),
    .misalign_err    (misalign_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] kind, input logic [63:0] tgt);
    redirect_valid  = 1'b1;
    redirect_kind   = kind;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
    redirect_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc;
    reset = 1'b1; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'b00;
    redirect_target = '0; trap = 1'b0; halt_req = 1'b0; resume = 1'b0;
    tick(); tick();

    // ---- Reset state ----
    check("rst_pc",        pc_out, 64'h0);
    check("rst_valid",     pc_valid, 0);
    check("rst_empty",     ras_empty, 1);
    check("rst_full",      ras_full, 0);
    check("rst_ovf",       ras_overflow, 0);
    check("rst_unf",       ras_underflow, 0);
    check("rst_misalign",  misalign_err, 0);

    reset = 1'b0;
    check("boot_valid", pc_valid, 0);
    tick();
    check("run_valid", pc_valid, 1);
    check("run_pc",    pc_out, 64'h0);

    // ---- Sequential fetch: ready 1,0,1 ----
    fetch_ready = 1'b1; tick(); check("seq_pc1", pc_out, 64'h4);
    fetch_ready = 1'b0; tick(); check("seq_pc2", pc_out, 64'h4);
    fetch_ready = 1'b1; tick(); check("seq_pc3", pc_out, 64'h8);
    fetch_ready = 1'b0; tick(); check("seq_hold", pc_out, 64'h8);

    // ---- Call / return ----
    redir(c_JUMP, 64'h20);
    check("jmp_pc", pc_out, 64'h20);
    redir(c_CALL, 64'h400);
    check("call_pc",    pc_out, 64'h400);
    check("call_empty", ras_empty, 0);
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
    check("callee_step", pc_out, 64'h404);
    redir(c_RET, 64'h3);  // target ignored, stack supplies 0x24
    check("ret_pc",       pc_out, 64'h24);
    check("ret_empty",    ras_empty, 1);
    check("ret_misalign", misalign_err, 0);

    // ---- Overflow: 9 calls into an 8-deep stack ----
    for (int i = 0; i < 9; i++) begin
      redir(c_CALL, 64'h1000 + 64'(i) * 64'h10);
      check("ovf_call_pc", pc_out, 64'h1000 + 64'(i) * 64'h10);
      if (i == 7) begin
        check("full_at_8", ras_full, 1);
        check("no_ovf_at_8", ras_overflow, 0);
      end
    end
    check("ovf_full", ras_full, 1);
    check("ovf_flag", ras_overflow, 1);
    // Returns yield links of calls 8..1 (call 0's link 0x28 was overwritten)
    for (int k = 8; k >= 1; k--) begin
      redir(c_RET, 64'h0);
      exp_pc = 64'h1004 + 64'(k - 1) * 64'h10;
      check("ovf_ret_pc", pc_out, exp_pc);
    end
    check("drained_empty", ras_empty, 1);
    check("drained_full",  ras_full, 0);
    check("pre_unf",       ras_underflow, 0);
    redir(c_RET, 64'h80);
    check("unf_pc",    pc_out, 64'h80);
    check("unf_flag",  ras_underflow, 1);
    check("unf_empty", ras_empty, 1);
    tick();
    check("unf_sticky", ras_underflow, 1);

    // ---- Priority ----
    trap = 1'b1;
    redir(c_CALL, 64'h400);
    trap = 1'b0;
    check("trap_pc",    pc_out, 64'h100);
    check("trap_empty", ras_empty, 1);
    redir(c_RET, 64'h84);  // empty stack proves the trapped call pushed nothing
    check("trap_nopush", pc_out, 64'h84);
    fetch_ready = 1'b1;
    redir(c_JUMP, 64'h300);
    check("redir_over_acc", pc_out, 64'h300);
    redir(2'b11, 64'h340);
    check("kind11_jump", pc_out, 64'h340);
    fetch_ready = 1'b0;

    // ---- Halt / misalign ----
    redir(c_JUMP, 64'h8);
    halt_req = 1'b1; fetch_ready = 1'b1; tick(); halt_req = 1'b0;
    check("halt_pc",    pc_out, 64'hC);
    check("halt_valid", pc_valid, 0);
    tick(); fetch_ready = 1'b0;
    check("halt_hold", pc_out, 64'hC);
    redir(c_JUMP, 64'h203);
    check("mis_pc",    pc_out, 64'h200);
    check("mis_flag",  misalign_err, 1);
    check("mis_valid", pc_valid, 0);
    tick();
    check("mis_pulse", misalign_err, 0);
    resume = 1'b1; tick(); resume = 1'b0;
    check("resume_valid", pc_valid, 1);
    check("resume_pc",    pc_out, 64'h200);
    halt_req = 1'b1; resume = 1'b1; tick();
    check("run_halt_wins", pc_valid, 0);
    tick(); halt_req = 1'b0; resume = 1'b0;
    check("halt_resume_wins", pc_valid, 1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("halt_again", pc_valid, 0);
    trap = 1'b1; tick(); trap = 1'b0;
    check("trap_from_halt_valid", pc_valid, 1);
    check("trap_from_halt_pc",    pc_out, 64'h100);

    // ---- Wrap at top of address space ----
    redir(c_JUMP, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
    check("wrap_pc", pc_out, 64'h0);
    check("wrap_nomis", misalign_err, 0);

    // ---- Asynchronous reset mid-run with pending redirect ----
    redir(c_CALL, 64'h600);
    redirect_valid = 1'b1; redirect_kind = c_JUMP; redirect_target = 64'h700;
    #2 reset = 1'b1;
    #1;
    check("async_pc",    pc_out, 64'h0);
    check("async_valid", pc_valid, 0);
    check("async_empty", ras_empty, 1);
    check("async_unf",   ras_underflow, 0);
    tick();
    redirect_valid = 1'b0; redirect_target = '0;
    check("async_hold_pc", pc_out, 64'h0);
    reset = 1'b0;
    check("reboot_valid", pc_valid, 0);
    tick();
    check("reboot_run", pc_valid, 1);
    check("reboot_pc",  pc_out, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
